// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data-side SRAM responder: FSM encodings,
// wait-state counter width, captured-request struct and the legal write-enable set.
package data_sram_resp_pkg;

  localparam int CNT_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [3:0] WEN_B0 = 4'b0001;
  localparam logic [3:0] WEN_B1 = 4'b0010;
  localparam logic [3:0] WEN_B2 = 4'b0100;
  localparam logic [3:0] WEN_B3 = 4'b1000;
  localparam logic [3:0] WEN_LO = 4'b0011;
  localparam logic [3:0] WEN_HI = 4'b1100;
  localparam logic [3:0] WEN_W  = 4'b1111;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic wen_legal(input logic [3:0] wen);
    case (wen)
      WEN_B0, WEN_B1, WEN_B2, WEN_B3, WEN_LO, WEN_HI, WEN_W: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// EX/MEM-facing data SRAM bus: the pipeline is the master, the responder the slave.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem;
  logic        data_sram_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq_for_mem, data_sram_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq_for_mem, data_sram_err
  );
endinterface

// File: rtl/data_sram_array.sv
// DEPTH x 32 single-port array, one 8-bit bank per byte lane, with a registered
// read port that holds its value until the next read (writes leave it alone).
module data_sram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic rd_en;
  assign rd_en = acc && (wen == 4'b0000);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_d, rd_q;

    always_ff @(posedge clk) begin
      if (acc && wen[g]) mem[idx] <= wdata[8*g +: 8];
    end

    always_comb begin
      rd_d = rd_q;
      if (rd_en) rd_d = mem[idx];
    end

    always_ff @(posedge clk) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_d;
    end

    assign rdata[8*g +: 8] = rd_q;
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder with LATENCY access edges per request and a stall request
// while waiting. Optional ALIGN_CHECK_EN suppresses illegal byte-enable writes and sets a sticky error.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  data_sram_resp_if.slave    bus
);

  localparam bit LAT_ONE = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_INIT = LAT_ONE ? '0 : CNT_W'(LATENCY - 2);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d, live, acc_req;
  logic             acc, arr_acc, stall;
  logic             unused_addr;

  assign live = '{wen: bus.data_sram_wen, addr: bus.data_sram_addr, wdata: bus.data_sram_wdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    acc     = 1'b0;
    acc_req = live;
    stall   = 1'b0;
    if (LAT_ONE) begin
      acc = bus.data_sram_en;
    end else begin
      case (state_q)
        ST_IDLE: begin
          stall = bus.data_sram_en;
          if (bus.data_sram_en) begin
            req_d   = live;
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // live bus is ignored here; the pipeline is holding the same request anyway
          stall   = (cnt_q != '0);
          acc_req = req_q;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            acc     = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic illegal, err_q, err_d;
  assign illegal = acc && (acc_req.wen != 4'b0000) && !wen_legal(acc_req.wen);
  assign arr_acc = acc && !rst && !illegal;
  assign err_d   = err_q | illegal;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign bus.data_sram_err = err_q;
`else
  assign arr_acc           = acc && !rst;
  assign bus.data_sram_err = 1'b0;
`endif

  assign bus.stallreq_for_mem = stall;
  // only the word index selects storage; offset and high bits wrap away
  assign unused_addr = ^{acc_req.addr[31:AW+2], acc_req.addr[1:0]};

  data_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .rst   (rst),
    .acc   (arr_acc),
    .wen   (acc_req.wen),
    .idx   (acc_req.addr[AW+1:2]),
    .wdata (acc_req.wdata),
    .rdata (bus.data_sram_rdata)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench: one responder at LATENCY=1 (bus_a) and one at LATENCY=3 (bus_b).
module tb_data_sram_resp;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  data_sram_resp_if bus_a ();
  data_sram_resp_if bus_b ();

  data_sram_resp #(.DEPTH(1024), .AW(10), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst_a), .bus(bus_a));
  data_sram_resp #(.DEPTH(1024), .AW(10), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst_b), .bus(bus_b));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv_a(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    bus_a.data_sram_en = en; bus_a.data_sram_wen = wen; bus_a.data_sram_addr = addr; bus_a.data_sram_wdata = wdata;
  endtask

  task automatic drv_b(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    bus_b.data_sram_en = en; bus_b.data_sram_wen = wen; bus_b.data_sram_addr = addr; bus_b.data_sram_wdata = wdata;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    drv_a(0, 4'h0, 32'h0, 32'h0);
    drv_b(0, 4'h0, 32'h0, 32'h0);
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'h0) begin nfail++; $display("FAIL rst_rdata_a got=%h exp=0", bus_a.data_sram_rdata); end
    ntests++; if (bus_a.stallreq_for_mem !== 1'b0) begin nfail++; $display("FAIL rst_stall_a got=%b exp=0", bus_a.stallreq_for_mem); end
    ntests++; if (bus_a.data_sram_err !== 1'b0) begin nfail++; $display("FAIL rst_err_a got=%b exp=0", bus_a.data_sram_err); end
    ntests++; if (bus_b.data_sram_rdata !== 32'h0) begin nfail++; $display("FAIL rst_rdata_b got=%h exp=0", bus_b.data_sram_rdata); end
    ntests++; if (bus_b.stallreq_for_mem !== 1'b0) begin nfail++; $display("FAIL rst_stall_b got=%b exp=0", bus_b.stallreq_for_mem); end
    step();
  endtask

  task automatic test_l1_basic();
    drv_a(1, 4'hF, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    ntests++; if (bus_a.stallreq_for_mem !== 1'b0) begin nfail++; $display("FAIL l1_stall got=%b exp=0", bus_a.stallreq_for_mem); end
    ntests++; if (bus_a.data_sram_rdata !== 32'h0) begin nfail++; $display("FAIL l1_wr_rdata got=%h exp=0", bus_a.data_sram_rdata); end
    step();
    drv_a(1, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'h0) begin nfail++; $display("FAIL l1_pre_rd got=%h exp=0", bus_a.data_sram_rdata); end
    step();
    drv_a(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL l1_rd got=%h exp=deadbeef", bus_a.data_sram_rdata); end
    step();
  endtask

  task automatic test_byte_write();
    drv_a(1, 4'b0100, 32'h10, 32'h00AB0000);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL bw_during got=%h exp=deadbeef", bus_a.data_sram_rdata); end
    step();
    drv_a(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'hDEADBEEF) begin nfail++; $display("FAIL bw_after got=%h exp=deadbeef", bus_a.data_sram_rdata); end
    step();
    drv_a(1, 4'h0, 32'h12, 32'h0);  // low address bits ignored
    step();
    drv_a(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'hDEABBEEF) begin nfail++; $display("FAIL bw_rd got=%h exp=deabbeef", bus_a.data_sram_rdata); end
    step();
  endtask

  task automatic test_wrap();
    drv_a(1, 4'hF, 32'h1000, 32'h11111111);
    step();
    drv_a(1, 4'h0, 32'h0, 32'h0);
    step();
    drv_a(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'h11111111) begin nfail++; $display("FAIL wrap got=%h exp=11111111", bus_a.data_sram_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    drv_a(1, 4'hF, 32'h20, 32'hA5A5A5A5); step();
    drv_a(1, 4'hF, 32'h24, 32'h5A5A5A5A); step();
    drv_a(1, 4'h0, 32'h20, 32'h0);        step();
    drv_a(1, 4'h0, 32'h24, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'hA5A5A5A5) begin nfail++; $display("FAIL b2b_rd0 got=%h exp=a5a5a5a5", bus_a.data_sram_rdata); end
    step();
    drv_a(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'h5A5A5A5A) begin nfail++; $display("FAIL b2b_rd1 got=%h exp=5a5a5a5a", bus_a.data_sram_rdata); end
    step(); step();
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== 32'h5A5A5A5A) begin nfail++; $display("FAIL b2b_hold got=%h exp=5a5a5a5a", bus_a.data_sram_rdata); end
    step();
  endtask

  task automatic test_align();
    logic [31:0] exp_odd, exp_lo;
    logic        exp_err;
`ifdef ALIGN_CHECK_EN
    exp_odd = 32'h00000000; exp_lo = 32'h0000BEEF; exp_err = 1'b1;
`else
    exp_odd = 32'h00FFFF00; exp_lo = 32'h00FFBEEF; exp_err = 1'b0;
`endif
    drv_a(1, 4'hF, 32'h30, 32'h0); step();
    drv_a(1, 4'b0110, 32'h30, 32'hFFFFFFFF);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_err !== 1'b0) begin nfail++; $display("FAIL al_err_pre got=%b exp=0", bus_a.data_sram_err); end
    step();
    drv_a(1, 4'h0, 32'h30, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_err !== exp_err) begin nfail++; $display("FAIL al_err got=%b exp=%b", bus_a.data_sram_err, exp_err); end
    step();
    drv_a(1, 4'b0011, 32'h30, 32'h0000BEEF);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== exp_odd) begin nfail++; $display("FAIL al_odd got=%h exp=%h", bus_a.data_sram_rdata, exp_odd); end
    step();
    drv_a(1, 4'h0, 32'h30, 32'h0); step();
    drv_a(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_a.data_sram_rdata !== exp_lo) begin nfail++; $display("FAIL al_legal got=%h exp=%h", bus_a.data_sram_rdata, exp_lo); end
    ntests++; if (bus_a.data_sram_err !== exp_err) begin nfail++; $display("FAIL al_sticky got=%b exp=%b", bus_a.data_sram_err, exp_err); end
    step();
    rst_a = 1'b1; step(); rst_a = 1'b0;
    @(negedge clk);
    ntests++; if (bus_a.data_sram_err !== 1'b0) begin nfail++; $display("FAIL al_err_rst got=%b exp=0", bus_a.data_sram_err); end
    ntests++; if (bus_a.data_sram_rdata !== 32'h0) begin nfail++; $display("FAIL al_rdata_rst got=%h exp=0", bus_a.data_sram_rdata); end
    step();
  endtask

  task automatic test_l3_read();
    drv_b(1, 4'hF, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b1) begin nfail++; $display("FAIL l3w_stall0 got=%b exp=1", bus_b.stallreq_for_mem); end
    step();
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b1) begin nfail++; $display("FAIL l3w_stall1 got=%b exp=1", bus_b.stallreq_for_mem); end
    step();
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b0) begin nfail++; $display("FAIL l3w_stall2 got=%b exp=0", bus_b.stallreq_for_mem); end
    step();
    drv_b(0, 4'h0, 32'h0, 32'h0); step();
    // read: cycle 0 request, cycle 1 address changes, cycle 3 data
    drv_b(1, 4'h0, 32'h40, 32'h0);
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b1) begin nfail++; $display("FAIL l3r_stall0 got=%b exp=1", bus_b.stallreq_for_mem); end
    step();
    bus_b.data_sram_addr = 32'h80;
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b1) begin nfail++; $display("FAIL l3r_stall1 got=%b exp=1", bus_b.stallreq_for_mem); end
    step();
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b0) begin nfail++; $display("FAIL l3r_stall2 got=%b exp=0", bus_b.stallreq_for_mem); end
    ntests++; if (bus_b.data_sram_rdata !== 32'h0) begin nfail++; $display("FAIL l3r_early got=%h exp=0", bus_b.data_sram_rdata); end
    step();
    drv_b(1, 4'h0, 32'h40, 32'h0);  // immediate re-request starts a new count
    @(negedge clk);
    ntests++; if (bus_b.data_sram_rdata !== 32'hCAFEF00D) begin nfail++; $display("FAIL l3r_data got=%h exp=cafef00d", bus_b.data_sram_rdata); end
    ntests++; if (bus_b.stallreq_for_mem !== 1'b1) begin nfail++; $display("FAIL l3rr_stall0 got=%b exp=1", bus_b.stallreq_for_mem); end
    step();
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b1) begin nfail++; $display("FAIL l3rr_stall1 got=%b exp=1", bus_b.stallreq_for_mem); end
    step();
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b0) begin nfail++; $display("FAIL l3rr_stall2 got=%b exp=0", bus_b.stallreq_for_mem); end
    step();
    drv_b(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_b.data_sram_rdata !== 32'hCAFEF00D) begin nfail++; $display("FAIL l3rr_data got=%h exp=cafef00d", bus_b.data_sram_rdata); end
    step();
  endtask

  task automatic test_l3_reset_abort();
    drv_b(1, 4'hF, 32'h40, 32'h12345678);
    step();
    rst_b = 1'b1;
    drv_b(0, 4'h0, 32'h0, 32'h0);
    step();
    rst_b = 1'b0;
    @(negedge clk);
    ntests++; if (bus_b.stallreq_for_mem !== 1'b0) begin nfail++; $display("FAIL ab_stall got=%b exp=0", bus_b.stallreq_for_mem); end
    ntests++; if (bus_b.data_sram_rdata !== 32'h0) begin nfail++; $display("FAIL ab_rdata got=%h exp=0", bus_b.data_sram_rdata); end
    step(); step();
    drv_b(1, 4'h0, 32'h40, 32'h0);
    step(); step(); step();
    drv_b(0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    ntests++; if (bus_b.data_sram_rdata !== 32'hCAFEF00D) begin nfail++; $display("FAIL ab_old got=%h exp=cafef00d", bus_b.data_sram_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_l1_basic();
    test_byte_write();
    test_wrap();
    test_back_to_back();
    test_align();
    test_l3_read();
    test_l3_reset_abort();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
